pifo_enq_deq_arb: RTL
=====================

PIFO_ENQ_DEQ_ARB -- requirements
Module: pifo_enq_deq_arb

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: enqueue buffer entries, power of two, 2..16.
REQ-002 Parameter MAX_PRIORITY, default 256: priority range; PRIO_WIDTH = clog2(MAX_PRIORITY).
REQ-003 Parameter DATA_WIDTH, default 8: payload width.
REQ-004 Parameter GAP_CYCLES, default 2: idle cycles forced after each PIFO command, 0..7.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low (0 = in reset).
REQ-007 i__enq_valid  input  1  producer offers an entry.
REQ-008 i__enq_priority / i__enq_data  input  PRIO_WIDTH / DATA_WIDTH  offered entry.
REQ-009 o__enq_ready  output  1  enqueue buffer not full and not in reset.
REQ-010 i__deq_req  input  1  consumer requests one dequeue; level, sampled in IDLE.
REQ-011 o__deq_valid / o__deq_priority / o__deq_data  output  1 / PRIO_WIDTH / DATA_WIDTH  held dequeue result.
REQ-012 i__deq_ready  input  1  consumer accepts result.
REQ-013 i__clear_all  input  1  flush everything.
REQ-014 o__pifo_in_valid / o__pifo_in_priority / o__pifo_in  output  1 / PRIO_WIDTH / DATA_WIDTH  push command to downstream PIFO.
REQ-015 i__pifo_in_ready  input  1  PIFO not full.
REQ-016 o__pifo_out_ready  output  1  pop command to PIFO.
REQ-017 i__pifo_out_valid / i__pifo_out_priority / i__pifo_out  input  1 / PRIO_WIDTH / DATA_WIDTH  PIFO head.
REQ-018 o__pifo_clear_all  output  1  clear forwarded to PIFO.
REQ-019 o__push_count / o__pop_count  output  16 / 16  statistics (see Configuration).

Function
REQ-020 Enqueue buffer SHALL be a FIFO_DEPTH-entry FIFO; write on i__enq_valid & o__enq_ready; o__enq_ready = not full AND reset high.
REQ-021 FSM states IDLE, ISSUE, GAP; at most one of o__pifo_in_valid, o__pifo_out_ready SHALL be high in any cycle, each only in ISSUE, for exactly one cycle.
REQ-022 IDLE: push eligible = buffer non-empty & i__pifo_in_ready; pop eligible = i__deq_req & i__pifo_out_valid & ~o__deq_valid.
REQ-023 One eligible -> grant it; both eligible -> grant opposite of last_grant; last_grant resets to POP (push wins first tie); IDLE -> ISSUE next cycle.
REQ-024 ISSUE push: drive buffer head on o__pifo_in_*, pop buffer same cycle.
REQ-025 ISSUE pop: capture i__pifo_out_priority / i__pifo_out into output register; o__deq_valid high next cycle.
REQ-026 ISSUE -> GAP for GAP_CYCLES cycles -> IDLE; GAP_CYCLES = 0 -> ISSUE -> IDLE directly.
REQ-027 Minimum command spacing SHALL be GAP_CYCLES + 2 cycles.
REQ-028 o__deq_* SHALL hold stable while o__deq_valid & ~i__deq_ready; cleared on handshake.
REQ-029 Producer writes SHALL continue in every FSM state; write to full buffer ignored (ready low).
REQ-030 Buffer read and write in same cycle when full: both SHALL occur, count unchanged, ready stays low that cycle.
REQ-031 i__clear_all: next cycle buffer empty, o__deq_valid 0, FSM IDLE, last_grant POP; o__pifo_clear_all = i__clear_all registered one cycle; clear overrides issue in same cycle (no command).

Reset
REQ-032 reset low at clock edge: buffer empty, FSM IDLE, last_grant POP, all outputs 0, counters 0.
REQ-033 Reset mid-ISSUE or GAP SHALL abort without further commands; o__enq_ready 0 while reset low.

Configuration
REQ-034 Macro PIFO_ARB_STATS_EN defined: o__push_count / o__pop_count increment on each push / pop command, wrap at 65535 -> 0, cleared by reset and i__clear_all.
REQ-035 Macro undefined: counter logic absent, both ports tied to 0; ports always present.

Verification
REQ-036 Enqueue prio 5,3,9 back-to-back, PIFO ready, GAP_CYCLES=2 -> o__pifo_in_valid at cycles 2,6,10 with 5,3,9, four-cycle spacing.
REQ-037 Buffer holds one entry, i__deq_req=1, PIFO valid head prio 7 -> push first, then pop after gap, then tie alternation continues.
REQ-038 FIFO_DEPTH=4, i__pifo_in_ready=0, 6 offers -> 4 accepted, o__enq_ready low after fourth, no push issued.
REQ-039 Pop result prio 12 data 0xA5, i__deq_ready low 5 cycles -> outputs held, no further pop until handshake.
REQ-040 i__clear_all during GAP with 3 buffered -> next cycle buffer empty, o__enq_ready 1, o__pifo_clear_all pulse 1 cycle, no command.
REQ-041 With PIFO_ARB_STATS_EN, 3 pushes 2 pops -> counts 3/2; without macro -> 0/0.

Source files
------------

// File: rtl/pifo_enq_deq_arb.sv
// pifo_enq_deq_arb
// Front end for a downstream PIFO. Producer entries are staged in a small
// FIFO and pushed into the PIFO one at a time. Consumer dequeue requests
// become pop commands whose result is held in an output register until the
// consumer accepts it. One arbiter interleaves pushes and pops. After every
// command it forces GAP_CYCLES idle cycles before the next one.
//
// Ports
//   clk, reset                        clock, synchronous active-low reset
//   i__enq_valid/_priority/_data      producer offer
//   o__enq_ready                      staging buffer can accept
//   i__deq_req                        consumer wants one dequeue (level)
//   o__deq_valid/_priority/_data      held dequeue result
//   i__deq_ready                      consumer accepts result
//   i__clear_all                      flush buffer, result and arbiter
//   o__pifo_in_valid/_priority, o__pifo_in   push command to PIFO
//   i__pifo_in_ready                  PIFO can take a push
//   o__pifo_out_ready                 pop command to PIFO
//   i__pifo_out_valid/_priority, i__pifo_out PIFO head
//   o__pifo_clear_all                 clear forwarded to PIFO, one cycle late
//   o__push_count/o__pop_count        command statistics
//
// Optional feature: define PIFO_ARB_STATS_EN to build the push/pop counters.
// Without it both count ports are tied to zero.
//
// state | meaning
// IDLE  | arbitrate between push and pop eligibility
// ISSUE | one command (push or pop) is on the PIFO interface this cycle
// GAP   | forced idle spacing after a command
module pifo_enq_deq_arb #(
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_PRIORITY = 256,
    parameter int DATA_WIDTH   = 8,
    parameter int GAP_CYCLES   = 2,
    localparam int PRIO_WIDTH  = $clog2(MAX_PRIORITY)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i__enq_valid,
    input  logic [PRIO_WIDTH-1:0] i__enq_priority,
    input  logic [DATA_WIDTH-1:0] i__enq_data,
    output logic                  o__enq_ready,
    input  logic                  i__deq_req,
    output logic                  o__deq_valid,
    output logic [PRIO_WIDTH-1:0] o__deq_priority,
    output logic [DATA_WIDTH-1:0] o__deq_data,
    input  logic                  i__deq_ready,
    input  logic                  i__clear_all,
    output logic                  o__pifo_in_valid,
    output logic [PRIO_WIDTH-1:0] o__pifo_in_priority,
    output logic [DATA_WIDTH-1:0] o__pifo_in,
    input  logic                  i__pifo_in_ready,
    output logic                  o__pifo_out_ready,
    input  logic                  i__pifo_out_valid,
    input  logic [PRIO_WIDTH-1:0] i__pifo_out_priority,
    input  logic [DATA_WIDTH-1:0] i__pifo_out,
    output logic                  o__pifo_clear_all,
    output logic [15:0]           o__push_count,
    output logic [15:0]           o__pop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0] GAP_LOAD = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

    state_t                state_q;
    logic                  issue_push_q, issue_pop_q;
    logic                  last_grant_push_q;
    logic [2:0]            gap_cnt_q;

    logic [PRIO_WIDTH-1:0] prio_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  deq_valid_q;
    logic [PRIO_WIDTH-1:0] deq_prio_q;
    logic [DATA_WIDTH-1:0] deq_data_q;
    logic                  pifo_clear_q;

    logic buf_full, buf_empty;
    logic push_cmd, pop_cmd, wr_en, rd_en;
    logic push_elig, pop_elig, grant_push, grant_pop;

    assign buf_full  = (count_q == FULL_CNT);
    assign buf_empty = (count_q == '0);

    // A clear or reset in the issue cycle suppresses the command entirely.
    assign push_cmd = issue_push_q & reset & ~i__clear_all;
    assign pop_cmd  = issue_pop_q  & reset & ~i__clear_all;

    assign rd_en = push_cmd;
    // A full buffer still takes the offered entry when the head leaves in the
    // same cycle; ready itself only reflects the full flag.
    assign wr_en = i__enq_valid & reset & ~i__clear_all & (~buf_full | rd_en);
    assign count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);

    assign push_elig  = ~buf_empty & i__pifo_in_ready;
    assign pop_elig   = i__deq_req & i__pifo_out_valid & ~deq_valid_q;
    // On a tie the side that did not win last time is granted.
    assign grant_push = push_elig & (~pop_elig | ~last_grant_push_q);
    assign grant_pop  = pop_elig  & (~push_elig | last_grant_push_q);

    always_ff @(posedge clk) begin
        if (!reset || i__clear_all) begin
            state_q           <= ST_IDLE;
            issue_push_q      <= 1'b0;
            issue_pop_q       <= 1'b0;
            last_grant_push_q <= 1'b0;
            gap_cnt_q         <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_push || grant_pop) begin
                        state_q           <= ST_ISSUE;
                        issue_push_q      <= grant_push;
                        issue_pop_q       <= grant_pop;
                        last_grant_push_q <= grant_push;
                    end
                end
                ST_ISSUE: begin
                    issue_push_q <= 1'b0;
                    issue_pop_q  <= 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 3'd0) state_q <= ST_IDLE;
                    else                   gap_cnt_q <= gap_cnt_q - 3'd1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            prio_mem_q[wr_ptr_q] <= i__enq_priority;
            data_mem_q[wr_ptr_q] <= i__enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || i__clear_all) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || i__clear_all) begin
            deq_valid_q <= 1'b0;
            deq_prio_q  <= '0;
            deq_data_q  <= '0;
        end else if (pop_cmd) begin
            deq_valid_q <= 1'b1;
            deq_prio_q  <= i__pifo_out_priority;
            deq_data_q  <= i__pifo_out;
        end else if (deq_valid_q && i__deq_ready) begin
            deq_valid_q <= 1'b0;
            deq_prio_q  <= '0;
            deq_data_q  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) pifo_clear_q <= 1'b0;
        else        pifo_clear_q <= i__clear_all;
    end

`ifdef PIFO_ARB_STATS_EN
    logic [15:0] push_cnt_q, pop_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset || i__clear_all) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
        end else begin
            if (push_cmd) push_cnt_q <= push_cnt_q + 16'd1;
            if (pop_cmd)  pop_cnt_q  <= pop_cnt_q + 16'd1;
        end
    end

    assign o__push_count = push_cnt_q;
    assign o__pop_count  = pop_cnt_q;
`else
    assign o__push_count = 16'd0;
    assign o__pop_count  = 16'd0;
`endif

    assign o__enq_ready        = ~buf_full & reset;
    assign o__pifo_in_valid    = push_cmd;
    assign o__pifo_in_priority = push_cmd ? prio_mem_q[rd_ptr_q] : '0;
    assign o__pifo_in          = push_cmd ? data_mem_q[rd_ptr_q] : '0;
    assign o__pifo_out_ready   = pop_cmd;
    assign o__deq_valid        = deq_valid_q;
    assign o__deq_priority     = deq_prio_q;
    assign o__deq_data         = deq_data_q;
    assign o__pifo_clear_all   = pifo_clear_q;

endmodule
